// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared FSM state encoding and ALU mode constants
// Ports: none (package). Imported by alu_core and alu_arbiter.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] MODE_ADD   = 4'b0000;
    localparam logic [3:0] MODE_SUB   = 4'b0001;
    localparam logic [3:0] MODE_CMP   = 4'b0010;
    localparam logic [3:0] MODE_AND   = 4'b0011;
    localparam logic [3:0] MODE_OR    = 4'b0100;
    localparam logic [3:0] MODE_NOT   = 4'b0101;
    localparam logic [3:0] MODE_INC   = 4'b0110;
    localparam logic [3:0] MODE_DEC   = 4'b0111;
    // Any mode with bit 3 set selects the shifter; bits [2:0] pick the shift.
    localparam logic [3:0] MODE_SHIFT = 4'b1000;

    localparam logic [2:0] SH_SHL1 = 3'd0;  // logical left by 1
    localparam logic [2:0] SH_SHR1 = 3'd1;  // logical right by 1
    localparam logic [2:0] SH_ASR1 = 3'd2;  // arithmetic right by 1
    localparam logic [2:0] SH_ROL1 = 3'd3;  // rotate left by 1
    localparam logic [2:0] SH_ROR1 = 3'd4;  // rotate right by 1
    localparam logic [2:0] SH_SHLB = 3'd5;  // logical left by b[1:0]
    localparam logic [2:0] SH_SHRB = 3'd6;  // logical right by b[1:0]
    localparam logic [2:0] SH_ASRB = 3'd7;  // arithmetic right by b[1:0]

endpackage

// File: rtl/alu_arbiter_alu_core.sv
// rtl/alu_arbiter_alu_core.sv - combinational 4-bit ALU/shifter (module alu_core)
// Ports: a_i, b_i [3:0] operands; m_i [3:0] mode; r_o [3:0] result; ovf_o carry-out for add/sub, else 0.
module alu_core
    import alu_arbiter_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [3:0] m_i,
    output logic [3:0] r_o,
    output logic       ovf_o
);

    logic [4:0] sum;

    always_comb begin
        r_o   = 4'd0;
        ovf_o = 1'b0;
        sum   = 5'd0;
        if (m_i[3]) begin
            case (m_i[2:0])
                SH_SHL1: r_o = {a_i[2:0], 1'b0};
                SH_SHR1: r_o = {1'b0, a_i[3:1]};
                SH_ASR1: r_o = {a_i[3], a_i[3:1]};
                SH_ROL1: r_o = {a_i[2:0], a_i[3]};
                SH_ROR1: r_o = {a_i[0], a_i[3:1]};
                SH_SHLB: r_o = a_i << b_i[1:0];
                SH_SHRB: r_o = a_i >> b_i[1:0];
                SH_ASRB: r_o = 4'($signed(a_i) >>> b_i[1:0]);
                default: r_o = 4'd0;
            endcase
        end else begin
            case (m_i)
                MODE_ADD: begin
                    sum   = {1'b0, a_i} + {1'b0, b_i};
                    r_o   = sum[3:0];
                    ovf_o = sum[4];
                end
                MODE_SUB: begin
                    // Two's-complement subtract; carry-out is the "no borrow" flag.
                    sum   = {1'b0, a_i} + {1'b0, ~b_i} + 5'd1;
                    r_o   = sum[3:0];
                    ovf_o = sum[4];
                end
                MODE_CMP: r_o = {1'b0, (a_i > b_i), (a_i == b_i), (a_i < b_i)};
                MODE_AND: r_o = a_i & b_i;
                MODE_OR:  r_o = a_i | b_i;
                MODE_NOT: r_o = ~a_i;
                MODE_INC: r_o = a_i + 4'd1;
                MODE_DEC: r_o = a_i - 4'd1;
                default:  r_o = 4'd0;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter around a shared alu_core with registered responses
// Ports: clk_i, rst_ni (async active-low); reqN_valid_i/reqN_ready_o/reqN_a_i/reqN_b_i/reqN_m_i request
//        channels (N=0,1); rspN_valid_o/rspN_ready_i response channels; rsp_r_o, rsp_ovf_o shared
//        registered result; busy_o (not IDLE); op_count_o completed responses (wraps).
// Config: ALU_ARB_RR_EN defined -> round-robin on ties; undefined -> requester 0 wins ties.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req0_valid_i,
    output logic       req0_ready_o,
    input  logic [3:0] req0_a_i,
    input  logic [3:0] req0_b_i,
    input  logic [3:0] req0_m_i,
    input  logic       req1_valid_i,
    output logic       req1_ready_o,
    input  logic [3:0] req1_a_i,
    input  logic [3:0] req1_b_i,
    input  logic [3:0] req1_m_i,
    output logic       rsp0_valid_o,
    input  logic       rsp0_ready_i,
    output logic       rsp1_valid_o,
    input  logic       rsp1_ready_i,
    output logic [3:0] rsp_r_o,
    output logic       rsp_ovf_o,
    output logic       busy_o,
    output logic [7:0] op_count_o
);

    state_e     state_q;
    logic [3:0] a_q, b_q, m_q;
    logic       id_q;
    logic [3:0] rsp_r_q;
    logic       rsp_ovf_q;
    logic       rsp0_valid_q, rsp1_valid_q;
    logic [7:0] op_count_q;

    logic       grant_d;     // requester that would win this cycle
    logic       accept_d;
    logic [3:0] op_a_d, op_b_d, op_m_d;
    logic       rsp_take_d;  // winning requester consumes the pending response
    logic [3:0] alu_r;
    logic       alu_ovf;

`ifdef ALU_ARB_RR_EN
    logic last_q;  // last granted requester; reset to 1 so requester 0 wins the first tie

    always_comb begin
        grant_d = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant_d = ~last_q;
        end else begin
            grant_d = req1_valid_i;
        end
    end
`else
    always_comb begin
        grant_d = ~req0_valid_i;
    end
`endif

    always_comb begin
        req0_ready_o = (state_q == ST_IDLE) && req0_valid_i && !grant_d;
        req1_ready_o = (state_q == ST_IDLE) && req1_valid_i && grant_d;
        accept_d     = req0_ready_o || req1_ready_o;
        op_a_d       = grant_d ? req1_a_i : req0_a_i;
        op_b_d       = grant_d ? req1_b_i : req0_b_i;
        op_m_d       = grant_d ? req1_m_i : req0_m_i;
        rsp_take_d   = id_q ? rsp1_ready_i : rsp0_ready_i;
    end

    alu_core u_alu_core (
        .a_i   (a_q),
        .b_i   (b_q),
        .m_i   (m_q),
        .r_o   (alu_r),
        .ovf_o (alu_ovf)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            a_q          <= 4'd0;
            b_q          <= 4'd0;
            m_q          <= 4'd0;
            id_q         <= 1'b0;
            rsp_r_q      <= 4'd0;
            rsp_ovf_q    <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            op_count_q   <= 8'd0;
`ifdef ALU_ARB_RR_EN
            last_q       <= 1'b1;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        a_q     <= op_a_d;
                        b_q     <= op_b_d;
                        m_q     <= op_m_d;
                        id_q    <= grant_d;
`ifdef ALU_ARB_RR_EN
                        last_q  <= grant_d;
`endif
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_r_q      <= alu_r;
                    rsp_ovf_q    <= alu_ovf;
                    rsp0_valid_q <= ~id_q;
                    rsp1_valid_q <= id_q;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_take_d) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        op_count_q   <= op_count_q + 8'd1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp0_valid_o = rsp0_valid_q;
    assign rsp1_valid_o = rsp1_valid_q;
    assign rsp_r_o      = rsp_r_q;
    assign rsp_ovf_o    = rsp_ovf_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign op_count_o   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard testbench for alu_arbiter (honours ALU_ARB_RR_EN)
module tb_alu_arbiter;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req0_m, req1_a, req1_b, req1_m;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [3:0] rsp_r;
    logic       rsp_ovf, busy;
    logic [7:0] op_count;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req0_m_i     (req0_m),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .req1_m_i     (req1_m),
        .rsp0_valid_o (rsp0_valid),
        .rsp0_ready_i (rsp0_ready),
        .rsp1_valid_o (rsp1_valid),
        .rsp1_ready_i (rsp1_ready),
        .rsp_r_o      (rsp_r),
        .rsp_ovf_o    (rsp_ovf),
        .busy_o       (busy),
        .op_count_o   (op_count)
    );

    typedef struct {
        logic       id;
        logic [3:0] r;
        logic       ovf;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    bit         tb_last  = 1'b1;
    logic [7:0] exp_count = 8'd0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference ALU written arithmetically; returns {ovf, r}.
    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] m);
        int ai = int'(a);
        int bi = int'(b);
        int sa = a[3] ? ai - 16 : ai;
        int sh = bi % 4;
        case (m)
            4'd0:  return {(ai + bi) > 15, 4'(ai + bi)};
            4'd1:  return {ai >= bi, 4'(ai - bi)};
            4'd2:  return {2'b00, ai > bi, ai == bi, ai < bi};
            4'd3:  return {1'b0, a & b};
            4'd4:  return {1'b0, a | b};
            4'd5:  return {1'b0, 4'(15 - ai)};
            4'd6:  return {1'b0, 4'(ai + 1)};
            4'd7:  return {1'b0, 4'(ai - 1)};
            4'd8:  return {1'b0, 4'(ai * 2)};
            4'd9:  return {1'b0, 4'(ai / 2)};
            4'd10: return {1'b0, 4'(sa >>> 1)};
            4'd11: return {1'b0, 4'(ai * 2 + ai / 8)};
            4'd12: return {1'b0, 4'(ai / 2 + (ai % 2) * 8)};
            4'd13: return {1'b0, 4'(ai * (1 << sh))};
            4'd14: return {1'b0, 4'(ai / (1 << sh))};
            default: return {1'b0, 4'(sa >>> sh)};
        endcase
    endfunction

    // Drives one request (or a tie), follows it through EXEC and RESP, holds the response
    // for 'hold' cycles, consumes it and checks the return to IDLE. g = observed grant.
    task automatic run_op(input bit v0, input logic [3:0] a0, input logic [3:0] b0, input logic [3:0] m0,
                          input bit v1, input logic [3:0] a1, input logic [3:0] b1, input logic [3:0] m1,
                          input int hold, output bit g);
        bit         eg;
        exp_t       e;
        logic [4:0] mr;
        logic [3:0] r_hold;
        logic       ovf_hold;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_m = m0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_m = m1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        eg = (v0 && v1) ? (RR ? !tb_last : 1'b0) : !v0;
        check("ready0_idle", req0_ready, int'(v0 && !eg));
        check("ready1_idle", req1_ready, int'(v1 && eg));
        g  = req1_ready;
        mr = eg ? model(a1, b1, m1) : model(a0, b0, m0);
        e.id = eg; e.r = mr[3:0]; e.ovf = mr[4];
        sb.push_back(e);
        tb_last = eg;
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("busy_exec", busy, 1);
        check("ready_exec", {req1_ready, req0_ready}, 0);
        check("rspv_exec", {rsp1_valid, rsp0_valid}, 0);
        @(negedge clk);
        check("rspv_latency", {rsp1_valid, rsp0_valid}, eg ? 2 : 1);
        r_hold = rsp_r; ovf_hold = rsp_ovf;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_r", rsp_r, r_hold);
            check("hold_ovf", rsp_ovf, ovf_hold);
            check("hold_rspv", {rsp1_valid, rsp0_valid}, eg ? 2 : 1);
            check("hold_ready", {req1_ready, req0_ready}, 0);
        end
        e = sb.pop_front();
        check("rsp_r", rsp_r, e.r);
        check("rsp_ovf", rsp_ovf, e.ovf);
        if (e.id) rsp1_ready = 1'b1;
        else rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        exp_count = exp_count + 8'd1;
        check("op_count", op_count, exp_count);
        check("busy_idle", busy, 0);
        check("rspv_idle", {rsp1_valid, rsp0_valid}, 0);
        check("reaccept", req0_ready || req1_ready, 1);
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tb_last = 1'b1;
        exp_count = 8'd0;
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit g;
        bit v0, v1;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0; req0_m = 4'd0;
        req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0; req1_m = 4'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {req1_ready, req0_ready}, 0);
        check("rst_rspv", {rsp1_valid, rsp0_valid}, 0);
        check("rst_r", rsp_r, 0);
        check("rst_ovf", rsp_ovf, 0);
        check("rst_busy", busy, 0);
        check("rst_count", op_count, 0);
        rst_n = 1'b1;

        run_op(1'b1, 4'd9, 4'd8, 4'b0000, 1'b0, 4'd0, 4'd0, 4'd0, 0, g);
        run_op(1'b1, 4'd3, 4'd3, 4'b0010, 1'b0, 4'd0, 4'd0, 4'd0, 0, g);
        run_op(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd0, 4'd0, 4'b0111, 0, g);
        run_op(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd5, 4'd7, 4'b0001, 5, g);
        for (int m = 0; m < 16; m++) begin
            run_op(1'b1, 4'(m * 7 + 9), 4'(m + 2), 4'(m), 1'b0, 4'd0, 4'd0, 4'd0, 0, g);
        end

        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, 4'(i), 4'd1, 4'd0, 1'b1, 4'(i), 4'd2, 4'd0, 0, g);
            check("tie_grant", g, RR ? (i % 2) : 0);
        end

        // Reset while the operation sits in EXEC.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd15; req0_m = 4'd0;
        @(negedge clk);
        req0_valid = 1'b0;
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_rspv", {rsp1_valid, rsp0_valid}, 0);
        check("arst_r", rsp_r, 0);
        check("arst_ovf", rsp_ovf, 0);
        check("arst_busy", busy, 0);
        check("arst_count", op_count, 0);
        check("arst_ready", {req1_ready, req0_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tb_last = 1'b1;
        exp_count = 8'd0;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_rspv", {rsp1_valid, rsp0_valid}, 0);
        end

        for (int i = 0; i < 256; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            run_op(v0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   v1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   0, g);
        end
        check("count_wrap", op_count, exp_count);
        check("count_wrap_zero", op_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
